branch_resolve_ctrl: RTL and testbench

Branch resolution controller for the pipeline's ID stage. It holds the architectural NZCV condition-code register and evaluates the 4-bit branch condition against it. When a flag-setting instruction is in EX at the same time as a branch in ID, it stalls the branch or forwards the flags. It drives PC-select, IF/ID flush and pipeline stall, and keeps saturating branch statistics counters.

---
 rtl/branch_resolve_ctrl.sv | 164 ++++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller for the ID stage: NZCV register, condition
// evaluation, flag-hazard stall/forward, PC-select/flush and branch stats.
module branch_resolve_ctrl #(
    parameter bit FWD_CC = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             id_b,
    input  logic [3:0]       id_cond,
    input  logic             ex_valid,
    input  logic             ex_s,
    input  logic [3:0]       alu_cc,
    output logic [3:0]       cc_q,
    output logic             take,
    output logic             flush_if,
    output logic             stall,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] not_taken_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        CC_WAIT = 2'd1,
        SQUASH  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_cc;
    logic [CNT_W-1:0] r_taken;
    logic [CNT_W-1:0] r_not_taken;
    logic [CNT_W-1:0] r_stall;

    logic             w_hazard;
    logic             w_t;
    logic             w_take;
    logic             w_stall;
    logic             w_nt;

    function automatic logic f_cond(input logic [3:0] code,
                                    input logic [3:0] cc);
        logic n;
        logic z;
        logic c;
        logic v;
        n = cc[3];
        z = cc[2];
        c = cc[1];
        v = cc[0];
        case (code)
            4'd0:    f_cond = z;
            4'd1:    f_cond = !z;
            4'd2:    f_cond = c;
            4'd3:    f_cond = !c;
            4'd4:    f_cond = n;
            4'd5:    f_cond = !n;
            4'd6:    f_cond = v;
            4'd7:    f_cond = !v;
            4'd8:    f_cond = c & !z;
            4'd9:    f_cond = !c | z;
            4'd10:   f_cond = (n == v);
            4'd11:   f_cond = (n != v);
            4'd12:   f_cond = !z & (n == v);
            4'd13:   f_cond = z | (n != v);
            4'd14:   f_cond = 1'b1;
            default: f_cond = 1'b0;
        endcase
    endfunction

    assign w_hazard = ex_valid & ex_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else if (!hold) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_t     = 1'b0;
        w_take  = 1'b0;
        w_stall = 1'b0;
        w_nt    = 1'b0;
        case (r_state)
            RUN: begin
                if (id_b) begin
                    if (w_hazard && !FWD_CC) begin
                        w_stall = 1'b1;
                        w_next  = CC_WAIT;
                    end else begin
                        w_t    = f_cond(id_cond, w_hazard ? alu_cc : r_cc);
                        w_take = w_t;
                        w_nt   = !w_t;
                        w_next = w_t ? SQUASH : RUN;
                    end
                end
            end
            CC_WAIT: begin
                // Flags from the stalled-on instruction were latched last edge
                w_t    = f_cond(id_cond, r_cc);
                w_take = w_t;
                w_nt   = !w_t;
                w_next = w_t ? SQUASH : RUN;
            end
            SQUASH: begin
                w_next = RUN;
            end
            default: begin
                w_next = RUN;
            end
        endcase
        if (hold) begin
            w_next  = r_state;
            w_take  = 1'b0;
            w_stall = 1'b0;
            w_nt    = 1'b0;
        end
    end

    assign take     = w_take & rst_n;
    assign flush_if = w_take & rst_n;
    assign stall    = w_stall & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cc <= 4'b0000;
        end else if (w_hazard && !hold) begin
            r_cc <= alu_cc;
        end
    end

    // Counter enables are already hold-gated; counters stick at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_taken     <= '0;
            r_not_taken <= '0;
            r_stall     <= '0;
        end else begin
            if (w_take && r_taken != CNT_MAX) begin
                r_taken <= r_taken + CNT_ONE;
            end
            if (w_nt && r_not_taken != CNT_MAX) begin
                r_not_taken <= r_not_taken + CNT_ONE;
            end
            if (w_stall && r_stall != CNT_MAX) begin
                r_stall <= r_stall + CNT_ONE;
            end
        end
    end

    assign cc_q          = r_cc;
    assign taken_cnt     = r_taken;
    assign not_taken_cnt = r_not_taken;
    assign stall_cnt     = r_stall;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: three instances (stall, forward, 2-bit
// counters) share stimulus and are checked against a behavioural model.
module tb_branch_resolve_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hold;
    logic       id_b;
    logic [3:0] id_cond;
    logic       ex_valid;
    logic       ex_s;
    logic [3:0] alu_cc;

    logic [3:0]  cc0, cc1, cc2;
    logic        take0, take1, take2;
    logic        fl0, fl1, fl2;
    logic        st0, st1, st2;
    logic [15:0] tc0, nc0, sc0;
    logic [15:0] tc1, nc1, sc1;
    logic [1:0]  tc2, nc2, sc2;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.FWD_CC(1'b0), .CNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .hold(hold), .id_b(id_b),
        .id_cond(id_cond), .ex_valid(ex_valid), .ex_s(ex_s),
        .alu_cc(alu_cc), .cc_q(cc0), .take(take0), .flush_if(fl0),
        .stall(st0), .taken_cnt(tc0), .not_taken_cnt(nc0),
        .stall_cnt(sc0)
    );

    branch_resolve_ctrl #(.FWD_CC(1'b1), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .hold(hold), .id_b(id_b),
        .id_cond(id_cond), .ex_valid(ex_valid), .ex_s(ex_s),
        .alu_cc(alu_cc), .cc_q(cc1), .take(take1), .flush_if(fl1),
        .stall(st1), .taken_cnt(tc1), .not_taken_cnt(nc1),
        .stall_cnt(sc1)
    );

    branch_resolve_ctrl #(.FWD_CC(1'b0), .CNT_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .hold(hold), .id_b(id_b),
        .id_cond(id_cond), .ex_valid(ex_valid), .ex_s(ex_s),
        .alu_cc(alu_cc), .cc_q(cc2), .take(take2), .flush_if(fl2),
        .stall(st2), .taken_cnt(tc2), .not_taken_cnt(nc2),
        .stall_cnt(sc2)
    );

    logic [3:0]  a_cc[3];
    logic        a_take[3];
    logic        a_fl[3];
    logic        a_st[3];
    logic [15:0] a_tc[3];
    logic [15:0] a_nc[3];
    logic [15:0] a_sc[3];

    assign a_cc[0] = cc0;
    assign a_cc[1] = cc1;
    assign a_cc[2] = cc2;
    assign a_take[0] = take0;
    assign a_take[1] = take1;
    assign a_take[2] = take2;
    assign a_fl[0] = fl0;
    assign a_fl[1] = fl1;
    assign a_fl[2] = fl2;
    assign a_st[0] = st0;
    assign a_st[1] = st1;
    assign a_st[2] = st2;
    assign a_tc[0] = tc0;
    assign a_tc[1] = tc1;
    assign a_tc[2] = {14'd0, tc2};
    assign a_nc[0] = nc0;
    assign a_nc[1] = nc1;
    assign a_nc[2] = {14'd0, nc2};
    assign a_sc[0] = sc0;
    assign a_sc[1] = sc1;
    assign a_sc[2] = {14'd0, sc2};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Conditions come in complementary pairs; odd codes invert the even one
    function automatic bit cond_ok(input logic [3:0] code,
                                   input logic [3:0] cc);
        bit n;
        bit z;
        bit c;
        bit v;
        bit base;
        n = cc[3];
        z = cc[2];
        c = cc[1];
        v = cc[0];
        case (code[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return code[0] ? !base : base;
    endfunction

    bit         m_sq[3];
    bit         m_wt[3];
    logic [3:0] m_cc[3];
    int         m_tc[3];
    int         m_nc[3];
    int         m_sc[3];
    int         m_max[3] = '{65535, 65535, 3};
    bit         m_fwd[3] = '{1'b0, 1'b1, 1'b0};

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            bit hz;
            bit t;
            bit et;
            bit es;
            bit nt;
            bit nsq;
            bit nwt;
            hz  = ex_valid && ex_s;
            et  = 0;
            es  = 0;
            nt  = 0;
            nsq = 0;
            nwt = 0;
            if (!rst_n) begin
                m_sq[i] = 0;
                m_wt[i] = 0;
                m_cc[i] = 4'b0000;
                m_tc[i] = 0;
                m_nc[i] = 0;
                m_sc[i] = 0;
            end else if (!hold) begin
                if (m_sq[i]) begin
                    t = 0;
                end else if (m_wt[i]) begin
                    t   = cond_ok(id_cond, m_cc[i]);
                    et  = t;
                    nt  = !t;
                    nsq = t;
                end else if (id_b) begin
                    if (hz && !m_fwd[i]) begin
                        es  = 1;
                        nwt = 1;
                    end else begin
                        t   = cond_ok(id_cond, hz ? alu_cc : m_cc[i]);
                        et  = t;
                        nt  = !t;
                        nsq = t;
                    end
                end
            end
            chk($sformatf("u%0d take", i), a_take[i], et);
            chk($sformatf("u%0d flush_if", i), a_fl[i], et);
            chk($sformatf("u%0d stall", i), a_st[i], es);
            chk($sformatf("u%0d cc_q", i), a_cc[i], m_cc[i]);
            chk($sformatf("u%0d taken_cnt", i), a_tc[i], m_tc[i]);
            chk($sformatf("u%0d not_taken_cnt", i), a_nc[i], m_nc[i]);
            chk($sformatf("u%0d stall_cnt", i), a_sc[i], m_sc[i]);
            if (rst_n && !hold) begin
                if (et && m_tc[i] < m_max[i]) m_tc[i]++;
                if (nt && m_nc[i] < m_max[i]) m_nc[i]++;
                if (es && m_sc[i] < m_max[i]) m_sc[i]++;
                if (hz) m_cc[i] = alu_cc;
                m_sq[i] = nsq;
                m_wt[i] = nwt;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        hold     = 0;
        id_b     = 0;
        ex_valid = 0;
        ex_s     = 0;
    endtask

    task automatic do_reset();
        cyc();
        idle();
        rst_n = 0;
        cyc();
        rst_n = 1;
    endtask

    logic [3:0] pin_cc[6]   = '{4'b1001, 4'b1001, 4'b0110,
                                4'b0110, 4'b1000, 4'b0100};
    logic [3:0] pin_code[6] = '{4'd10, 4'd12, 4'd8, 4'd9, 4'd11, 4'd12};
    bit         pin_exp[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        rst_n = 0;
        idle();
        id_cond = 0;
        alu_cc  = 0;
        repeat (2) cyc();
        settle();
        chk("rst cc_q", cc0, 4'b0000);
        chk("rst take", take0, 1'b0);
        chk("rst taken_cnt", tc0, 16'd0);
        cyc();
        rst_n = 1;

        // Taken on Z without hazard, then a squash cycle
        cyc();
        ex_valid = 1;
        ex_s     = 1;
        alu_cc   = 4'b0100;
        cyc();
        ex_valid = 0;
        ex_s     = 0;
        id_b     = 1;
        id_cond  = 4'd0;
        settle();
        chk("t1 cc_q", cc0, 4'b0100);
        chk("t1 take", take0, 1'b1);
        chk("t1 flush_if", fl0, 1'b1);
        cyc();
        settle();
        chk("t1 squash take", take0, 1'b0);
        cyc();
        id_b = 0;
        settle();
        chk("t1 taken_cnt", tc0, 16'd1);

        // Flag hazard: stall vs forward
        do_reset();
        cyc();
        id_b     = 1;
        id_cond  = 4'd0;
        ex_valid = 1;
        ex_s     = 1;
        alu_cc   = 4'b0100;
        settle();
        chk("t2 stall0", st0, 1'b1);
        chk("t2 take0", take0, 1'b0);
        chk("t2 take1", take1, 1'b1);
        chk("t2 stall1", st1, 1'b0);
        cyc();
        ex_valid = 0;
        ex_s     = 0;
        settle();
        chk("t2 cc0", cc0, 4'b0100);
        chk("t2 take0 c2", take0, 1'b1);
        chk("t2 stall0 c2", st0, 1'b0);
        chk("t2 take1 c2", take1, 1'b0);
        cyc();
        id_b = 0;
        settle();
        chk("t2 stall_cnt0", sc0, 16'd1);
        chk("t2 stall_cnt1", sc1, 16'd0);

        // All codes against all flag values
        do_reset();
        for (int cc = 0; cc < 16; cc++) begin
            cyc();
            idle();
            ex_valid = 1;
            ex_s     = 1;
            alu_cc   = 4'(cc);
            for (int code = 0; code < 16; code++) begin
                cyc();
                ex_valid = 0;
                ex_s     = 0;
                id_b     = 1;
                id_cond  = 4'(code);
                settle();
                if (code == 14) chk("sweep always", take0, 1'b1);
                if (code == 15) chk("sweep never", take0, 1'b0);
                cyc();
                id_b = 0;
            end
        end
        settle();
        chk("sweep taken_cnt", tc0, 16'd128);
        chk("sweep not_taken_cnt", nc0, 16'd128);
        chk("sat taken_cnt", tc2, 2'd3);
        chk("sat not_taken_cnt", nc2, 2'd3);

        for (int k = 0; k < 6; k++) begin
            cyc();
            ex_valid = 1;
            ex_s     = 1;
            alu_cc   = pin_cc[k];
            cyc();
            ex_valid = 0;
            ex_s     = 0;
            id_b     = 1;
            id_cond  = pin_code[k];
            settle();
            chk($sformatf("pin %0d", k), take0, pin_exp[k]);
            cyc();
            id_b = 0;
        end

        // Hold while waiting on flags
        do_reset();
        cyc();
        id_b     = 1;
        id_cond  = 4'd0;
        ex_valid = 1;
        ex_s     = 1;
        alu_cc   = 4'b0100;
        cyc();
        ex_valid = 0;
        ex_s     = 0;
        hold     = 1;
        settle();
        chk("hold take", take0, 1'b0);
        chk("hold stall", st0, 1'b0);
        chk("hold cc_q", cc0, 4'b0100);
        cyc();
        ex_valid = 1;
        ex_s     = 1;
        alu_cc   = 4'b1111;
        settle();
        chk("hold take 2", take0, 1'b0);
        cyc();
        ex_valid = 0;
        ex_s     = 0;
        settle();
        chk("hold cc frozen", cc0, 4'b0100);
        cyc();
        hold = 0;
        settle();
        chk("release take", take0, 1'b1);
        chk("release flush", fl0, 1'b1);
        cyc();
        settle();
        chk("release once", take0, 1'b0);
        cyc();
        id_b = 0;
        settle();
        chk("hold taken_cnt", tc0, 16'd1);
        chk("hold stall_cnt", sc0, 16'd1);

        // Reset during SQUASH and during CC_WAIT
        cyc();
        id_b    = 1;
        id_cond = 4'd14;
        settle();
        chk("sq take", take0, 1'b1);
        cyc();
        rst_n = 0;
        settle();
        chk("sq rst take", take0, 1'b0);
        chk("sq rst cc_q", cc0, 4'b0000);
        chk("sq rst taken_cnt", tc0, 16'd0);
        cyc();
        rst_n = 1;
        settle();
        chk("post rst take", take0, 1'b1);
        cyc();
        id_b = 0;
        cyc();
        id_b     = 1;
        id_cond  = 4'd0;
        ex_valid = 1;
        ex_s     = 1;
        alu_cc   = 4'b0100;
        settle();
        chk("wt stall", st0, 1'b1);
        cyc();
        rst_n    = 0;
        ex_valid = 0;
        ex_s     = 0;
        settle();
        chk("wt rst take", take0, 1'b0);
        cyc();
        rst_n = 1;
        id_b  = 0;
        settle();
        chk("wt rst take 2", take0, 1'b0);
        chk("wt rst cc_q", cc0, 4'b0000);

        // Not-taken followed directly by a taken branch
        cyc();
        id_b    = 1;
        id_cond = 4'd15;
        settle();
        chk("b2b nt", take0, 1'b0);
        cyc();
        id_cond = 4'd14;
        settle();
        chk("b2b t", take0, 1'b1);
        cyc();
        id_b = 0;
        repeat (2) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
